// File: rtl/fp_normalize_round.sv
// fp_normalize_round: 3-stage normalize/round-to-nearest-even back end packing a raw adder sum into binary32
//   clk, rst             : clock, synchronous active-high reset
//   in_vld / in_rdy      : input beat handshake (in_rdy = ~(res_vld & ~out_rdy))
//   in_sign, in_exp      : sign and signed biased exponent (EXP_W bits) of the raw sum
//   in_mant              : {carry, hidden, fraction[22:0], guard, round, sticky}
//   in_state             : upstream class OK=00 NAN=01 INF=10 NUL=11
//   result, state        : packed binary32 result and its class
//   res_vld / out_rdy    : output handshake; result/state hold while stalled
module fp_normalize_round #(
    parameter int EXP_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [27:0]      in_mant,
    input  logic [1:0]       in_state,
    output logic [31:0]      result,
    output logic [1:0]       state,
    output logic             res_vld,
    input  logic             out_rdy
);
    localparam int E = EXP_W + 1;
    localparam logic [1:0] OK = 2'b00, NAN = 2'b01, INF = 2'b10, NUL = 2'b11;

    // Position of the leading one in a 27-bit value, counted from bit 26; 27 when zero.
    function automatic logic [4:0] lzc27(input logic [26:0] m);
        lzc27 = 5'd27;
        for (int i = 0; i < 27; i++)
            if (m[i]) lzc27 = 5'(26 - i);
    endfunction

    logic en;
    assign en     = ~(res_vld & ~out_rdy);
    assign in_rdy = en;

    // Input capture
    logic                v0, s0_sign;
    logic signed [E-1:0] s0_exp;
    logic [27:0]         s0_mant;
    logic [1:0]          s0_st;

    always_ff @(posedge clk) begin
        if (rst) begin
            v0 <= 1'b0;
        end else if (en) begin
            v0 <= in_vld;
            if (in_vld) begin
                s0_sign <= in_sign;
                s0_exp  <= E'($signed(in_exp));
                s0_mant <= in_mant;
                s0_st   <= in_state;
            end
        end
    end

    // S1: absorb the carry by a right shift (keeping the lost bit in sticky) or count leading zeros
    logic [26:0]         c1_mant;
    logic signed [E-1:0] c1_exp;
    logic [4:0]          c1_lzc;
    logic                c1_zero;

    always_comb begin
        c1_mant = s0_mant[27] ? {s0_mant[27:2], s0_mant[1] | s0_mant[0]} : s0_mant[26:0];
        c1_exp  = s0_exp + E'(s0_mant[27]);
        c1_lzc  = s0_mant[27] ? 5'd0 : lzc27(s0_mant[26:0]);
        c1_zero = (s0_mant == 28'd0) && (s0_st == OK);
    end

    logic                v1, s1_sign, s1_zero;
    logic signed [E-1:0] s1_exp;
    logic [26:0]         s1_mant;
    logic [4:0]          s1_lzc;
    logic [1:0]          s1_st;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
        end else if (en) begin
            v1 <= v0;
            if (v0) begin
                s1_sign <= s0_sign & ~c1_zero;
                s1_exp  <= c1_exp;
                s1_mant <= c1_mant;
                s1_lzc  <= c1_lzc;
                s1_zero <= c1_zero;
                s1_st   <= s0_st;
            end
        end
    end

    // S2: normalize left; sticky stays ORed into bit 0. Non-positive exponents flush to zero.
    logic [26:0]         c2_mant;
    logic signed [E-1:0] c2_exp;
    logic [1:0]          c2_st;

    always_comb begin
        c2_mant = (s1_mant << s1_lzc) | {26'd0, s1_mant[0]};
        c2_exp  = s1_exp - E'(s1_lzc);
        c2_st   = (s1_st != OK) ? s1_st : (s1_zero || c2_exp <= 0) ? NUL : OK;
    end

    logic                v2, s2_sign;
    logic signed [E-1:0] s2_exp;
    logic [26:0]         s2_mant;
    logic [1:0]          s2_st;

    always_ff @(posedge clk) begin
        if (rst) begin
            v2 <= 1'b0;
        end else if (en) begin
            v2 <= v1;
            if (v1) begin
                s2_sign <= s1_sign;
                s2_exp  <= c2_exp;
                s2_mant <= c2_mant;
                s2_st   <= c2_st;
            end
        end
    end

    // S3: round to nearest even; a carry out of the 24-bit significand wraps the fraction to 0 and bumps exp
    logic                up, rcarry, ovf;
    logic [22:0]         c3_frac;
    logic signed [E-1:0] c3_exp;
    logic [31:0]         c3_res;
    logic [1:0]          c3_st;

    always_comb begin
        up      = s2_mant[2] & (s2_mant[1] | s2_mant[0] | s2_mant[3]);
        rcarry  = up & (&s2_mant[26:3]);
        c3_frac = s2_mant[25:3] + 23'(up);
        c3_exp  = s2_exp + E'(rcarry);
        ovf     = c3_exp >= E'(255);
        c3_res  = (s2_st == NAN) ? 32'h7FC0_0000 :
                  (s2_st == NUL) ? {s2_sign, 31'd0} :
                  (s2_st == INF || ovf) ? {s2_sign, 8'hFF, 23'd0} :
                  {s2_sign, c3_exp[7:0], c3_frac};
        c3_st   = (s2_st == OK && ovf) ? INF : s2_st;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_vld <= 1'b0;
            result  <= 32'd0;
            state   <= 2'b00;
        end else if (en) begin
            res_vld <= v2;
            if (v2) begin
                result <= c3_res;
                state  <= c3_st;
            end
        end
    end
endmodule

// File: tb/tb_fp_normalize_round.sv
// tb_fp_normalize_round: directed-vector scoreboard bench for fp_normalize_round
module tb_fp_normalize_round;
    localparam int EXP_W = 10;
    localparam logic [1:0] OK = 2'b00, NAN = 2'b01, INF = 2'b10, NUL = 2'b11;

    logic             clk = 1'b0, rst = 1'b1, in_vld = 1'b0, in_rdy, in_sign = 1'b0;
    logic [EXP_W-1:0] in_exp = '0;
    logic [27:0]      in_mant = '0;
    logic [1:0]       in_state = OK;
    logic [31:0]      result;
    logic [1:0]       state;
    logic             res_vld, out_rdy = 1'b1;

    int nvec = 0, nfail = 0;
    logic [33:0] q[$];
    logic [33:0] want;

    fp_normalize_round #(.EXP_W(EXP_W)) dut (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .in_sign(in_sign),
        .in_exp(in_exp), .in_mant(in_mant), .in_state(in_state), .result(result),
        .state(state), .res_vld(res_vld), .out_rdy(out_rdy)
    );

    always #5 clk = ~clk;

    // Monitor: compare on every consumed result, and check holding while stalled
    always @(negedge clk) begin
        if (!rst && res_vld) begin
            if (out_rdy) begin
                nvec++;
                if (q.size() == 0) begin
                    nfail++;
                    $display("FAIL extra_result: got %h/%0d, expected no result", result, state);
                end else begin
                    want = q.pop_front();
                    if ({result, state} !== want) begin
                        nfail++;
                        $display("FAIL result: got %h/%0d, expected %h/%0d", result, state, want[33:2], want[1:0]);
                    end
                end
            end else if (q.size() > 0) begin
                nvec++;
                if ({result, state} !== q[0]) begin
                    nfail++;
                    $display("FAIL stall_hold: got %h/%0d, expected %h/%0d", result, state, q[0][33:2], q[0][1:0]);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp_v);
        nvec++;
        if (got !== exp_v) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp_v);
        end
    endtask

    task automatic send(input logic s, input logic [EXP_W-1:0] e, input logic [27:0] m,
                        input logic [1:0] st, input logic [31:0] r, input logic [1:0] rs);
        int n = 0;
        logic acc = 1'b0;
        in_vld = 1'b1; in_sign = s; in_exp = e; in_mant = m; in_state = st;
        do begin
            @(negedge clk);
            acc = in_rdy;
            if (acc) q.push_back({r, rs});
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) begin
            nvec++;
            nfail++;
            $display("FAIL send_timeout: in_rdy got 0, expected 1 within 200 cycles");
        end
        in_vld = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_left", 32'(q.size()), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_res_vld", 32'(res_vld), 32'd0);
        chk("rst_result", result, 32'h0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_in_rdy", 32'(in_rdy), 32'd1);
        rst = 1'b0;
        // carry, rounding, LZC, underflow, overflow, specials
        send(0, 10'd127, 28'h8000000, OK,  32'h40000000, OK);
        send(0, 10'd127, 28'h7FFFFFC, OK,  32'h40000000, OK);
        send(0, 10'd127, 28'h4000004, OK,  32'h3F800000, OK);
        send(0, 10'd127, 28'h400000C, OK,  32'h3F800002, OK);
        send(0, 10'd127, 28'h8000009, OK,  32'h40000001, OK);
        send(0, 10'd130, 28'h0800000, OK,  32'h3F800000, OK);
        send(1, 10'd130, 28'h0800000, OK,  32'hBF800000, OK);
        send(1, 10'd127, 28'h0000000, OK,  32'h00000000, NUL);
        send(0, 10'd3,   28'h0000008, OK,  32'h00000000, NUL);
        send(0, 10'd1,   28'h4000000, OK,  32'h00800000, OK);
        send(1, 10'd0,   28'h4000000, OK,  32'h80000000, NUL);
        send(0, 10'h3FB, 28'h4000000, OK,  32'h00000000, NUL);
        send(0, 10'd254, 28'h8000000, OK,  32'h7F800000, INF);
        send(1, 10'd254, 28'h7FFFFFC, OK,  32'hFF800000, INF);
        send(0, 10'd127, 28'h0123456, NAN, 32'h7FC00000, NAN);
        send(1, 10'd0,   28'h0000000, INF, 32'hFF800000, INF);
        send(1, 10'd5,   28'h4000000, NUL, 32'h80000000, NUL);
        drain();
        // backpressure: four beats fill the pipe, then in_rdy must drop
        out_rdy = 1'b0;
        for (int k = 1; k <= 4; k++)
            send(0, EXP_W'(127 + k), 28'h4000000, OK, {1'b0, 8'(127 + k), 23'd0}, OK);
        chk("in_rdy_full", 32'(in_rdy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("in_rdy_held", 32'(in_rdy), 32'd0);
        fork
            begin
                for (int k = 5; k <= 6; k++)
                    send(0, EXP_W'(127 + k), 28'h4000000, OK, {1'b0, 8'(127 + k), 23'd0}, OK);
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                out_rdy = 1'b1;
            end
        join
        drain();
        // reset with three beats in flight
        send(0, 10'd127, 28'h4000000, OK, 32'h3F800000, OK);
        send(0, 10'd128, 28'h4000000, OK, 32'h40000000, OK);
        send(0, 10'd129, 28'h4000000, OK, 32'h40800000, OK);
        rst = 1'b1;
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            chk("rst_flush", 32'(res_vld), 32'd0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
